x_uart_tx_fifo: RTL
===================

Name: x_uart_tx_fifo

Overview:
Buffered UART transmitter: the transmit end of the 8N1 serial link the design's receiver listens on.
- Accepts bytes on a valid/accept handshake into a small FIFO.
- Serialises them onto o_tx, LSB first, back-to-back with no idle gap while data remains.
- Lets the command driver burst response bytes without stalling per byte.

Parameters:
p_clk_hz  50000000  core clock frequency in Hz
p_baud  115200  line baud rate; divisor DIV = p_clk_hz / p_baud, integer-truncated (434 at defaults)
p_depth  4  FIFO entries; power of two, >= 2

Ports:
i_clk  input  1  core clock, rising edge
i_rst_n  input  1  synchronous active-low reset
i_valid  input  1  byte offered on i_data
i_data  input  8  byte to transmit
o_accept  output  1  FIFO can take a byte this cycle
o_tx  output  1  serial line, idle high
o_busy  output  1  high while a frame is on the line or the FIFO is non-empty
o_level  output  $clog2(p_depth)+1  current FIFO occupancy, 0..p_depth

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - o_tx=1, o_busy=0, o_level=0.
  - FIFO pointers cleared; FSM to IDLE; baud and bit counters cleared.
  - o_accept=0 while i_rst_n is low, 1 on the first cycle after release.
  - Reset mid-frame aborts the frame; o_tx returns high on that edge.
- Handshake:
  - o_accept = i_rst_n & (level != p_depth), combinational.
  - Push when i_valid & o_accept at a rising edge. i_data is sampled only then.
  - i_valid while o_accept=0 is ignored and causes no error.
- FIFO:
  - Circular buffer with (log2 p_depth)+1-bit pointers; full/empty decided from the MSB compare.
  - No bypass: a push to an empty FIFO still goes through storage.
  - Push and pop on the same edge leave level unchanged.
  - When full, a pop on the same edge does not raise o_accept in that cycle; no push is possible that cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If FIFO non-empty, pop the head into the shift register and go to START. The o_tx low transition is registered on that same edge.
  - START: o_tx=0 for DIV cycles.
  - DATA: 8 bits, LSB first, each held DIV cycles; 3-bit bit counter wraps 7->0 on exit.
  - STOP: o_tx=1 for DIV cycles. On the last STOP cycle:
    - FIFO non-empty: pop and go directly to START, so there is no extra idle cycle.
    - FIFO empty: go to IDLE.
- Timing:
  - Frame length is exactly 10*DIV cycles.
  - Latency: byte pushed at edge N into an idle, empty block gives o_tx=0 from edge N+1.
- Baud counter: counts 0..DIV-1 and wraps; it is reset to 0 on every state entry.
- o_busy = (state != IDLE) | (level != 0), registered-equivalent (no combinational path from i_valid).
- o_tx is driven from a flop; no glitches.

Optional Feature:
X_UART_TX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for DIV cycles.
  - Frame length becomes 11*DIV cycles (8E1).
- Undefined:
  - No PARITY state and no parity logic; 8N1 as above.
- Ports and parameters are identical in both builds.

Test Plan:
- Reset release, i_valid=0 for 1000 cycles -> o_tx=1, o_busy=0, o_level=0, o_accept=1 throughout.
- Push 0xA5 at edge N, defaults -> o_tx low N+1..N+434. Bits 1,0,1,0,0,1,0,1 at 434 cycles each. Stop high for 434 cycles. o_busy falls at the end of stop.
- Push 0x00, 0xFF, 0x55 on consecutive cycles -> three frames with no idle between stop and next start. Total 3*4340 cycles. o_level peaks at 2 (one byte already popped).
- Hold i_valid=1 with incrementing data from idle, p_depth=4 -> o_accept drops after 5 pushes (1 in shift register + 4 queued). Exactly bytes 0..4 are transmitted in order. Data offered while o_accept=0 is never sent.
- Assert i_rst_n=0 for one cycle mid-DATA of byte 0x3C with 2 bytes queued -> o_tx=1 next edge, o_level=0. No further frames; next push transmits normally.
- With X_UART_TX_PARITY_EN: push 0x07 -> parity bit 1 after bit 7, frame 4774 cycles. Push 0x03 -> parity bit 0.

Source files
------------

// File: rtl/x_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// x_uart_tx_fifo
//   Buffered UART transmitter. Bytes offered on a valid/accept handshake are
//   queued in a small circular FIFO and serialised onto o_tx, LSB first.
//   Frames are sent back-to-back with no idle gap while data remains, so a
//   command driver can burst response bytes without stalling on each byte.
//
// Parameters
//   p_clk_hz  core clock frequency in Hz
//   p_baud    line baud rate; bit time DIV = p_clk_hz / p_baud (truncated)
//   p_depth   FIFO entries, power of two, >= 2
//
// Ports
//   i_clk     core clock, rising edge
//   i_rst_n   synchronous active-low reset
//   i_valid   byte offered on i_data
//   i_data    byte to transmit
//   o_accept  FIFO can take a byte this cycle (combinational)
//   o_tx      serial line, idle high, driven from a flop
//   o_busy    a frame is on the line or the FIFO holds data
//   o_level   FIFO occupancy, 0..p_depth
//
// Build option
//   X_UART_TX_PARITY_EN  when defined, an even-parity bit is sent between
//                        the data bits and the stop bit (8E1 framing).
// ---------------------------------------------------------------------------
module x_uart_tx_fifo #(
  parameter int p_clk_hz = 50000000,
  parameter int p_baud   = 115200,
  parameter int p_depth  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [7:0]                 i_data,
  output logic                       o_accept,
  output logic                       o_tx,
  output logic                       o_busy,
  output logic [$clog2(p_depth):0]   o_level
);

  localparam int DIV = p_clk_hz / p_baud;
  localparam int AW  = $clog2(p_depth);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

`ifdef X_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem_q [p_depth];
  logic [AW:0]   wrPtr_q;
  logic [AW:0]   rdPtr_q;
  logic [AW:0]   level;
  logic          fifoFull;
  logic          fifoEmpty;
  logic          push;
  logic          pop;
  logic [7:0]    headByte;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baudEnd;

  // Pointers carry one extra wrap bit: equal means empty, equal index with
  // differing wrap bit means full.
  assign level     = wrPtr_q - rdPtr_q;
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign headByte  = mem_q[rdPtr_q[AW-1:0]];

  // Full is judged on the registered pointers, so a pop on the same edge
  // cannot open a slot for a push in that cycle.
  assign o_accept = i_rst_n & ~fifoFull;
  assign push     = i_valid & o_accept;

  assign o_level = level;
  assign o_busy  = (state_q != IDLE) | (level != '0);
  assign o_tx    = tx_q;

  // FIFO storage holds no control state, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wrPtr_q[AW-1:0]] <= i_data;
    end
  end

  // Write and read pointers; push and pop on one edge leave level unchanged.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  assign baudEnd = (baud_q == BAUD_LAST);

  // Frame sequencer. The baud counter restarts at zero on each state entry
  // and on each data bit. The last stop cycle pops straight into the next
  // start so consecutive frames have no idle gap.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          shift_d = headByte;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baudEnd) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baudEnd) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef X_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef X_UART_TX_PARITY_EN
      PARITY: begin
        if (baudEnd) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baudEnd) begin
          baud_d = '0;
          if (!fifoEmpty) begin
            pop     = 1'b1;
            shift_d = headByte;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so o_tx changes on the very
  // edge that enters each bit period.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[bit_d];
`ifdef X_UART_TX_PARITY_EN
      PARITY: tx_d = ^shift_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Sequencer registers; reset aborts any frame and idles the line.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
